// File: rtl/gate_result_checker.sv
// Response checker for a gate under test: compares (in_vec, in_out) samples against TRUTH.
// Optional ascending-sweep order check when GATE_CHK_ORDER_CHECK_EN is defined.
module gate_result_checker #(
    parameter int unsigned          N_IN  = 2,
    parameter logic [(2**N_IN)-1:0] TRUTH = 4'b1000,
    parameter int unsigned          CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_vec,
    input  logic             in_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [N_IN-1:0]  first_err_vec,
    output logic             first_err_vld
);

    // The vector counter must hold 2**N_IN even when err_count is configured narrower.
    localparam int unsigned      VcntW   = (CNT_W > N_IN + 1) ? CNT_W : N_IN + 1;
    localparam int unsigned      NumVec  = 2**N_IN;
    localparam logic [VcntW-1:0] LastIdx = VcntW'(NumVec - 1);
    localparam logic [CNT_W-1:0] ErrMax  = '1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [VcntW-1:0]  vcnt_q;
    logic [CNT_W-1:0]  err_count_q;
    logic [CNT_W-1:0]  err_count_d;
    logic [N_IN-1:0]   first_err_vec_q;
    logic              first_err_vld_q;
    logic              pass_q;
    logic              accept;
    logic              sample_err;
    logic              err_inc;
    logic              enter_run;

    assign in_ready      = (state_q == StRun);
    assign busy          = (state_q == StRun);
    assign done          = (state_q == StDone);
    assign pass          = pass_q;
    assign err_count     = err_count_q;
    assign first_err_vec = first_err_vec_q;
    assign first_err_vld = first_err_vld_q;

    always_comb begin
        accept     = in_valid & in_ready;
        sample_err = (in_out != TRUTH[in_vec]);
`ifdef GATE_CHK_ORDER_CHECK_EN
        // Sample k of a pass must carry in_vec == k; counts once even with a mismatch.
        sample_err = sample_err | (in_vec != vcnt_q[N_IN-1:0]);
`endif
        err_inc     = accept & sample_err;
        err_count_d = err_count_q;
        if (err_inc && (err_count_q != ErrMax)) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
        enter_run = start & ((state_q == StIdle) | (state_q == StDone));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            vcnt_q          <= '0;
            err_count_q     <= '0;
            first_err_vec_q <= '0;
            first_err_vld_q <= 1'b0;
            pass_q          <= 1'b0;
        end else if (enter_run) begin
            state_q         <= StRun;
            vcnt_q          <= '0;
            err_count_q     <= '0;
            first_err_vec_q <= '0;
            first_err_vld_q <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            case (state_q)
                StRun: begin
                    if (accept) begin
                        vcnt_q      <= vcnt_q + VcntW'(1);
                        err_count_q <= err_count_d;
                        if (err_inc && !first_err_vld_q) begin
                            first_err_vec_q <= in_vec;
                            first_err_vld_q <= 1'b1;
                        end
                        if (vcnt_q == LastIdx) begin
                            state_q <= StDone;
                            pass_q  <= (err_count_d == '0);
                        end
                    end
                end
                StIdle, StDone: ;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_result_checker.sv
// Scoreboard bench for gate_result_checker: default AND build plus a narrow-counter variant.
module tb_gate_result_checker;

    typedef struct packed {
        logic       pass;
        logic [7:0] err;
        logic       vld;
        logic [2:0] vec;
    } exp_t;

    logic clk;
    logic rst;

    logic       start_a, in_valid_a, in_ready_a, in_out_a;
    logic [1:0] in_vec_a;
    logic       busy_a, done_a, pass_a, first_err_vld_a;
    logic [7:0] err_count_a;
    logic [1:0] first_err_vec_a;

    logic       start_b, in_valid_b, in_ready_b, in_out_b;
    logic [2:0] in_vec_b;
    logic       busy_b, done_b, pass_b, first_err_vld_b;
    logic [1:0] err_count_b;
    logic [2:0] first_err_vec_b;

    exp_t qa[$];
    exp_t qb[$];
    int   n_vec = 0;
    int   n_err = 0;

    gate_result_checker dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_vec(in_vec_a), .in_out(in_out_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_count_a), .first_err_vec(first_err_vec_a),
        .first_err_vld(first_err_vld_a)
    );

    gate_result_checker #(.N_IN(3), .TRUTH(8'hFF), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_vec(in_vec_b), .in_out(in_out_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_count_b), .first_err_vec(first_err_vec_b),
        .first_err_vld(first_err_vld_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation on every rising edge of done.
    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_a && !prev) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    chk("a_pass", {31'd0, pass_a}, {31'd0, e.pass});
                    chk("a_err_count", {24'd0, err_count_a}, {24'd0, e.err});
                    chk("a_first_vld", {31'd0, first_err_vld_a}, {31'd0, e.vld});
                    chk("a_first_vec", {30'd0, first_err_vec_a}, {29'd0, e.vec});
                end
            end
            prev = done_a;
        end
    end

    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (done_b && !prev) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = qb.pop_front();
                    chk("b_pass", {31'd0, pass_b}, {31'd0, e.pass});
                    chk("b_err_count", {30'd0, err_count_b}, {24'd0, e.err});
                    chk("b_first_vld", {31'd0, first_err_vld_b}, {31'd0, e.vld});
                    chk("b_first_vec", {29'd0, first_err_vec_b}, {29'd0, e.vec});
                end
            end
            prev = done_b;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [1:0] v, input logic o);
        in_valid_a = 1'b1;
        in_vec_a   = v;
        in_out_a   = o;
        step();
        in_valid_a = 1'b0;
    endtask

    task automatic send_b(input logic [2:0] v, input logic o);
        in_valid_b = 1'b1;
        in_vec_b   = v;
        in_out_b   = o;
        step();
        in_valid_b = 1'b0;
    endtask

    task automatic start_pulse_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (3) step();
        chk(name, qa.size() + qb.size(), 32'd0);
    endtask

    task automatic check_idle_a(input string name);
        chk({name, "_ready"}, {31'd0, in_ready_a}, 32'd0);
        chk({name, "_busy"}, {31'd0, busy_a}, 32'd0);
        chk({name, "_done"}, {31'd0, done_a}, 32'd0);
        chk({name, "_pass"}, {31'd0, pass_a}, 32'd0);
        chk({name, "_err"}, {24'd0, err_count_a}, 32'd0);
        chk({name, "_fvld"}, {31'd0, first_err_vld_a}, 32'd0);
        chk({name, "_fvec"}, {30'd0, first_err_vec_a}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start_a = 1'b0; in_valid_a = 1'b0; in_vec_a = '0; in_out_a = 1'b0;
        start_b = 1'b0; in_valid_b = 1'b0; in_vec_b = '0; in_out_b = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        check_idle_a("reset");

        // Test 1: correct AND sweep.
        start_pulse_a();
        chk("t1_busy", {31'd0, busy_a}, 32'd1);
        qa.push_back('{pass: 1'b1, err: 8'd0, vld: 1'b0, vec: 3'd0});
        send_a(2'b00, 1'b0);
        send_a(2'b01, 1'b0);
        send_a(2'b10, 1'b0);
        chk("t1_no_early_done", {31'd0, done_a}, 32'd0);
        send_a(2'b11, 1'b1);
        chk("t1_done", {31'd0, done_a}, 32'd1);
        drain("t1_drain");

        // Test 2: restart from DONE, wrong output on row 11.
        start_pulse_a();
        qa.push_back('{pass: 1'b0, err: 8'd1, vld: 1'b1, vec: 3'd3});
        send_a(2'b00, 1'b0);
        send_a(2'b01, 1'b0);
        send_a(2'b10, 1'b0);
        send_a(2'b11, 1'b0);
        drain("t2_drain");

        // Test 5: restart clears the previous pass's error state.
        start_pulse_a();
        chk("t5_busy", {31'd0, busy_a}, 32'd1);
        chk("t5_done", {31'd0, done_a}, 32'd0);
        chk("t5_err", {24'd0, err_count_a}, 32'd0);
        chk("t5_fvld", {31'd0, first_err_vld_a}, 32'd0);
        qa.push_back('{pass: 1'b1, err: 8'd0, vld: 1'b0, vec: 3'd0});
        send_a(2'b00, 1'b0);
        send_a(2'b01, 1'b0);
        send_a(2'b10, 1'b0);
        send_a(2'b11, 1'b1);
        drain("t5_drain");

        // Test 4: samples in IDLE ignored; rst mid-run abandons the pass.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_a(2'(i), 1'b1);
            chk("t4_idle_ready", {31'd0, in_ready_a}, 32'd0);
            chk("t4_idle_err", {24'd0, err_count_a}, 32'd0);
        end
        start_pulse_a();
        send_a(2'b00, 1'b1);
        send_a(2'b01, 1'b1);
        chk("t4_mid_err", {24'd0, err_count_a}, 32'd2);
        chk("t4_mid_fvld", {31'd0, first_err_vld_a}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_idle_a("t4_after_rst");

        // Test 6: correct outputs presented out of order.
        start_pulse_a();
`ifdef GATE_CHK_ORDER_CHECK_EN
        qa.push_back('{pass: 1'b0, err: 8'd2, vld: 1'b1, vec: 3'd1});
`else
        qa.push_back('{pass: 1'b1, err: 8'd0, vld: 1'b0, vec: 3'd0});
`endif
        send_a(2'b01, 1'b0);
        send_a(2'b00, 1'b0);
        send_a(2'b10, 1'b0);
        send_a(2'b11, 1'b1);
        drain("t6_drain");

        // Test 3: N_IN=3, all-ones truth, 2-bit err_count saturates.
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        qb.push_back('{pass: 1'b0, err: 8'd3, vld: 1'b1, vec: 3'd0});
        for (int i = 0; i < 8; i++) begin
            send_b(3'(i), 1'b0);
            if (i == 3) chk("t3_sat_mid", {30'd0, err_count_b}, 32'd3);
            if (i == 6) chk("t3_no_early_done", {31'd0, done_b}, 32'd0);
        end
        chk("t3_done", {31'd0, done_b}, 32'd1);
        drain("t3_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
